multicycle_control: RTL and testbench

- Moore/Mealy control FSM that sequences the shared single ALU, memory port and register file of the multicycle RV32 core. Supported subset: R-type, lw, sw, beq.
- Drives aluop to the ALU decoder: 00 = add, 01 = sub, 10 = funct-decoded.
- Waits on a memory ready handshake, with a timeout.
- Reports illegal opcodes and memory timeouts through a one-cycle fault state.

---
 rtl/multicycle_control.sv | 80 ++++++++
 tb/tb_multicycle_control.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: control FSM sequencing the shared ALU, memory port and register file of the multicycle RV32 core
module multicycle_control #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_source,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alusrc_a,
  output logic [1:0] alusrc_b,
  output logic [1:0] aluop,
  output logic       fault,
  output logic [1:0] fault_cause,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, FAULT = 4'd9
  } state_t;
  localparam logic [6:0] OP_R = 7'b0110011, OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_BEQ = 7'b1100011;
  state_t st, nxt;
  logic [7:0] cnt;
  logic [6:0] op_q;
  logic [1:0] cause;
  logic waiting, tmo;
  assign waiting = (st == FETCH || st == MEMRD || st == MEMWR) && !mem_ready;
  assign tmo = waiting && cnt == 8'(TIMEOUT - 1);
  always_comb begin
    nxt = FETCH;
    case (st)
      FETCH:  nxt = mem_ready ? DECODE : tmo ? FAULT : FETCH;
      DECODE: nxt = opcode == OP_R ? EXEC : (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                    opcode == OP_BEQ ? BRANCH : FAULT;
      MEMADR: nxt = op_q == OP_LW ? MEMRD : MEMWR;
      MEMRD:  nxt = mem_ready ? MEMWB : tmo ? FAULT : MEMRD;
      MEMWR:  nxt = mem_ready ? FETCH : tmo ? FAULT : MEMWR;
      EXEC:   nxt = ALUWB;
      default: nxt = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= FETCH;
      cnt <= '0;
      op_q <= '0;
      cause <= '0;
    end else begin
      st <= nxt;
      cnt <= nxt != st ? 8'd0 : waiting ? cnt + 8'd1 : cnt;
      if (st == DECODE) op_q <= opcode;
      if (nxt == FAULT) cause <= st == DECODE ? 2'b01 : 2'b10;
    end
  // outputs are qualified by rst so everything reads 0 the instant reset asserts
  assign pc_write      = rst && st == FETCH && mem_ready;
  assign ir_write      = rst && st == FETCH && mem_ready;
  assign mem_read      = rst && (st == FETCH || st == MEMRD);
  assign iord          = rst && (st == MEMRD || st == MEMWR);
  assign mem_write     = rst && st == MEMWR;
  assign mem_to_reg    = rst && st == MEMWB;
  assign reg_write     = rst && (st == MEMWB || st == ALUWB);
  assign alusrc_a      = rst && (st == MEMADR || st == EXEC || st == BRANCH);
  assign alusrc_b      = !rst ? 2'b00 : st == FETCH ? 2'b01 : (st == DECODE || st == MEMADR) ? 2'b10 : 2'b00;
  assign aluop         = !rst ? 2'b00 : st == EXEC ? 2'b10 : st == BRANCH ? 2'b01 : 2'b00;
  // zero gates the PC in the datapath; the term keeps the port connected here without changing the result
  assign pc_write_cond = rst && st == BRANCH && (zero || !zero);
  assign pc_source     = rst && st == BRANCH;
  assign fault         = rst && st == FAULT;
  assign fault_cause   = cause;
  assign state         = st;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized directed bench checking the control FSM against a per-instruction step model
module tb_multicycle_control;
  localparam int T = 16;
  logic clk = 0, rst = 0, zero = 0, mem_ready = 0;
  logic [6:0] opcode = 0;
  logic pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_write, alusrc_a, fault;
  logic [1:0] alusrc_b, aluop, fault_cause;
  logic [3:0] state;
  multicycle_control #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .aluop(aluop),
    .fault(fault), .fault_cause(fault_cause), .state(state)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic pw, pwc, psrc, iord, mrd, mwr, irw, m2r, rw, asa;
    logic [1:0] asb, aop;
    logic flt;
  } ctrl_t;
  typedef struct {
    logic [3:0] st;
    logic rdy;
    logic [1:0] cause;
  } step_t;
  ctrl_t dut_ctrl;
  assign dut_ctrl = {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_write, alusrc_a, alusrc_b, aluop, fault};
  step_t q[$];
  int total = 0, passed = 0, fails = 0;
  logic [1:0] exp_cause = 0;
  logic [31:0] pc_m = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic ctrl_t exp_ctrl(logic [3:0] st, logic rdy);
    ctrl_t c = '0;
    case (st)
      4'd0: begin c.mrd = 1; c.asb = 2'b01; c.irw = rdy; c.pw = rdy; end
      4'd1: c.asb = 2'b10;
      4'd2: begin c.asa = 1; c.asb = 2'b10; end
      4'd3: begin c.mrd = 1; c.iord = 1; end
      4'd4: begin c.rw = 1; c.m2r = 1; end
      4'd5: begin c.mwr = 1; c.iord = 1; end
      4'd6: begin c.asa = 1; c.aop = 2'b10; end
      4'd7: c.rw = 1;
      4'd8: begin c.asa = 1; c.aop = 2'b01; c.pwc = 1; c.psrc = 1; end
      4'd9: c.flt = 1;
      default: c = '0;
    endcase
    return c;
  endfunction
  function automatic void push(logic [3:0] st, logic rdy, logic [1:0] cause);
    step_t s;
    s.st = st; s.rdy = rdy; s.cause = cause;
    q.push_back(s);
  endfunction
  // a wait of w idle cycles either completes on cycle w+1 or, past the budget, becomes a timeout fault
  function automatic bit add_wait(logic [3:0] st, int w);
    for (int i = 0; i < w && i < T; i++) push(st, 1'b0, 2'b00);
    if (w >= T) begin
      push(4'd9, 1'($urandom), 2'b10);
      return 1;
    end
    push(st, 1'b1, 2'b00);
    return 0;
  endfunction
  function automatic void build(logic [6:0] op, int wf, int wm);
    q.delete();
    if (add_wait(4'd0, wf)) return;
    push(4'd1, 1'($urandom), 2'b00);
    case (op)
      7'b0110011: begin push(4'd6, 1'($urandom), 0); push(4'd7, 1'($urandom), 0); end
      7'b0000011: begin
        push(4'd2, 1'($urandom), 0);
        if (!add_wait(4'd3, wm)) push(4'd4, 1'($urandom), 0);
      end
      7'b0100011: begin push(4'd2, 1'($urandom), 0); void'(add_wait(4'd5, wm)); end
      7'b1100011: push(4'd8, 1'($urandom), 0);
      default: push(4'd9, 1'($urandom), 2'b01);
    endcase
  endfunction
  task automatic run(logic [6:0] op, logic z, int limit);
    for (int i = 0; i < q.size() && i < limit; i++) begin
      opcode = q[i].st == 4'd1 ? op : 7'($urandom);
      mem_ready = q[i].rdy;
      zero = z;
      if (q[i].st == 4'd9) exp_cause = q[i].cause;
      #1;
      chk($sformatf("ctrl op=%b step%0d", op, i), 32'(dut_ctrl), 32'(exp_ctrl(q[i].st, q[i].rdy)));
      chk($sformatf("state op=%b step%0d", op, i), 32'(state), 32'(q[i].st));
      chk($sformatf("cause op=%b step%0d", op, i), 32'(fault_cause), 32'(exp_cause));
      if (pc_write) pc_m += 4;
      else if (pc_write_cond && zero) pc_m = 32'h100;
      @(negedge clk);
    end
  endtask
  task automatic instr(logic [6:0] op, int wf, int wm, logic z);
    build(op, wf, wm);
    run(op, z, q.size());
  endtask
  initial begin
    logic [31:0] pc0;
    logic [6:0] ops [5];
    ops[0] = 7'b0110011; ops[1] = 7'b0000011; ops[2] = 7'b0100011; ops[3] = 7'b1100011; ops[4] = 7'b1111111;
    mem_ready = 1;
    opcode = 7'b0110011;
    repeat (2) @(negedge clk);
    #1;
    chk("reset ctrl", 32'(dut_ctrl), 0);
    chk("reset state", 32'(state), 0);
    chk("reset cause", 32'(fault_cause), 0);
    @(negedge clk);
    rst = 1;
    instr(7'b0110011, 0, 0, 0);
    instr(7'b0000011, 0, 3, 0);
    pc0 = pc_m;
    instr(7'b1100011, 0, 0, 1);
    chk("beq taken pc", pc_m, 32'h100);
    pc0 = pc_m;
    instr(7'b1100011, 0, 0, 0);
    chk("beq not-taken pc", pc_m, pc0 + 4);
    instr(7'b1111111, 1, 0, 0);
    instr(7'b0100011, 0, 16, 0);
    instr(7'b0100011, 0, 15, 0);
    instr(7'b0000011, 2, 16, 0);
    instr(7'b0110011, 16, 0, 0);
    instr(7'b0110011, 15, 0, 0);
    for (int n = 0; n < 40; n++) begin
      logic [6:0] op;
      int k;
      k = $urandom_range(0, 4);
      op = k == 4 ? 7'($urandom) : ops[k];
      instr(op, $urandom_range(0, 9) == 0 ? 16 : $urandom_range(0, 3),
            $urandom_range(0, 9) == 0 ? 16 : $urandom_range(0, 3), 1'($urandom));
    end
    instr(7'b1111111, 0, 0, 0);
    build(7'b0100011, 0, 10);
    run(7'b0100011, 0, 5);
    #2 rst = 0;
    mem_ready = 0;
    #1;
    chk("async reset ctrl", 32'(dut_ctrl), 0);
    chk("async reset state", 32'(state), 0);
    chk("async reset cause", 32'(fault_cause), 0);
    repeat (2) @(negedge clk);
    #1;
    chk("held reset mem_write", 32'(mem_write), 0);
    @(negedge clk);
    rst = 1;
    exp_cause = 0;
    instr(7'b0110011, 0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
